// File: rtl/serial_subtractor_32_pkg.sv
// Shared definitions for the bit-serial subtractor: widths, FSM state
// encodings and the signed-overflow rule used when the result is committed.
package serial_subtractor_32_pkg;

  localparam int DATA_INDEX_LIMIT = 31;
  localparam int DATA_WIDTH       = DATA_INDEX_LIMIT + 1;
  localparam int SSUB_CNT_WIDTH   = 5;

  // Counter value while the final (MSB) bit is being processed.
  localparam logic [SSUB_CNT_WIDTH-1:0] SSUB_CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    SSUB_IDLE  = 2'd0,
    SSUB_SHIFT = 2'd1,
    SSUB_DONE  = 2'd2
  } ssub_state_e;

  // Subtraction overflows when the operands have different signs and the
  // result sign differs from the minuend sign.
  function automatic logic sub_overflow(input logic a_msb,
                                        input logic b_msb,
                                        input logic r_msb);
    return (a_msb ^ b_msb) & (a_msb ^ r_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_32_if.sv
// Start/result bundle between the control unit (master) and the serial
// subtractor (slave).
interface serial_subtractor_32_if;
  import serial_subtractor_32_pkg::*;

  logic                  start;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] d;
  logic                  bout;
  logic                  ovf;
  logic                  busy;
  logic                  done;

  modport master (
    output start, a, b,
    input  d, bout, ovf, busy, done
  );

  modport slave (
    input  start, a, b,
    output d, bout, ovf, busy, done
  );

endinterface

// File: rtl/serial_subtractor_32_full_sub.sv
// One-bit full subtractor built from gate primitives:
//   d  = a ^ b ^ bi
//   bo = (~a & b) | (~(a ^ b) & bi)
module serial_subtractor_32_full_sub (
  output wire d,
  output wire bo,
  input  wire a,
  input  wire b,
  input  wire bi
);

  wire axb_s;
  wire na_s;
  wire naxb_s;
  wire gen_s;
  wire prop_s;

  xor u_x1 (axb_s, a, b);
  xor u_x2 (d, axb_s, bi);
  not u_n1 (na_s, a);
  and u_a1 (gen_s, na_s, b);
  not u_n2 (naxb_s, axb_s);
  and u_a2 (prop_s, naxb_s, bi);
  or  u_o1 (bo, gen_s, prop_s);

endmodule

// File: rtl/serial_subtractor_32.sv
// Bit-serial 32-bit subtractor D = A - B, LSB first, one bit per clock.
// A start is accepted in IDLE or DONE; 32 edges later the result is
// committed and DONE pulses for one cycle. Results hold until the next
// commit or reset.
module serial_subtractor_32
  import serial_subtractor_32_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_32_if.slave bus
);

  ssub_state_e               state_r;
  ssub_state_e               state_next_s;
  logic                      load_s;
  logic                      last_s;

  logic [DATA_WIDTH-1:0]     a_sh_r;
  logic [DATA_WIDTH-1:0]     b_sh_r;
  // Upper 31 bits of the partial result; the newest bit enters at the MSB.
  logic [DATA_WIDTH-2:0]     diff_sh_r;
  logic [DATA_WIDTH-1:0]     diff_next_s;
  logic                      borrow_r;
  logic [SSUB_CNT_WIDTH-1:0] cnt_r;
  logic                      a_msb_r;
  logic                      b_msb_r;

  logic [DATA_WIDTH-1:0]     d_r;
  logic                      bout_r;
  logic                      ovf_r;
  logic                      busy_r;
  logic                      done_r;

  logic                      diff_s;
  logic                      borrow_s;

  // Single bit slice shared by every cycle of the computation.
  serial_subtractor_32_full_sub u_fs (
    .d  (diff_s),
    .bo (borrow_s),
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .bi (borrow_r)
  );

  assign diff_next_s = {diff_s, diff_sh_r};

  // Next-state logic plus load/commit strobes; START only matters in IDLE/DONE.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      SSUB_IDLE: begin
        if (bus.start) begin
          state_next_s = SSUB_SHIFT;
          load_s       = 1'b1;
        end else begin
          state_next_s = SSUB_IDLE;
        end
      end
      SSUB_SHIFT: begin
        if (cnt_r == SSUB_CNT_LAST) begin
          state_next_s = SSUB_DONE;
          last_s       = 1'b1;
        end else begin
          state_next_s = SSUB_SHIFT;
        end
      end
      SSUB_DONE: begin
        if (bus.start) begin
          state_next_s = SSUB_SHIFT;
          load_s       = 1'b1;
        end else begin
          state_next_s = SSUB_IDLE;
        end
      end
      default: begin
        state_next_s = SSUB_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SSUB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, serial shifting and result commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r    <= {DATA_WIDTH{1'b0}};
      b_sh_r    <= {DATA_WIDTH{1'b0}};
      diff_sh_r <= {(DATA_WIDTH-1){1'b0}};
      borrow_r  <= 1'b0;
      cnt_r     <= {SSUB_CNT_WIDTH{1'b0}};
      a_msb_r   <= 1'b0;
      b_msb_r   <= 1'b0;
      d_r       <= {DATA_WIDTH{1'b0}};
      bout_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (load_s) begin
      a_sh_r    <= bus.a;
      b_sh_r    <= bus.b;
      a_msb_r   <= bus.a[DATA_WIDTH-1];
      b_msb_r   <= bus.b[DATA_WIDTH-1];
      diff_sh_r <= {(DATA_WIDTH-1){1'b0}};
      borrow_r  <= 1'b0;
      cnt_r     <= {SSUB_CNT_WIDTH{1'b0}};
    end else if (state_r == SSUB_SHIFT) begin
      a_sh_r    <= {1'b0, a_sh_r[DATA_WIDTH-1:1]};
      b_sh_r    <= {1'b0, b_sh_r[DATA_WIDTH-1:1]};
      diff_sh_r <= diff_next_s[DATA_WIDTH-1:1];
      borrow_r  <= borrow_s;
      cnt_r     <= cnt_r + 5'd1;
      if (last_s) begin
        d_r    <= diff_next_s;
        bout_r <= borrow_s;
        ovf_r  <= sub_overflow(a_msb_r, b_msb_r, diff_s);
      end
    end
  end

  // BUSY/DONE are registered decodes of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == SSUB_SHIFT);
      done_r <= (state_next_s == SSUB_DONE);
    end
  end

  assign bus.d    = d_r;
  assign bus.bout = bout_r;
  assign bus.ovf  = ovf_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Self-checking bench for serial_subtractor_32: directed corner cases,
// random operands against an arithmetic reference, back-to-back streaming
// and reset abort.
module tb_serial_subtractor_32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_subtractor_32_if bus_if ();

  serial_subtractor_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain two's-complement arithmetic; returns {bout, ovf, d}.
  function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic        bo;
    logic        ov;
    d  = a - b;
    bo = (a < b);
    ov = (a[31] != b[31]) && (d[31] != a[31]);
    return {bo, ov, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait up to 40 edges for DONE; returns edges waited (-1 on timeout).
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus_if.done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // One isolated operation with explicit expected results.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_bo, input logic exp_ov);
    int n;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.start = 1'b1;
    tick();                                  // E0
    bus_if.start = 1'b0;
    bus_if.a     = $urandom;                 // operands may change after E0
    bus_if.b     = $urandom;
    check({tag, "_busy_e0"}, {31'd0, bus_if.busy}, 32'd1);
    check({tag, "_done_e0"}, {31'd0, bus_if.done}, 32'd0);
    wait_done(n);
    check({tag, "_latency"}, n, 32'd32);
    check({tag, "_d"}, bus_if.d, exp_d);
    check({tag, "_bout"}, {31'd0, bus_if.bout}, {31'd0, exp_bo});
    check({tag, "_ovf"}, {31'd0, bus_if.ovf}, {31'd0, exp_ov});
    check({tag, "_busy_done"}, {31'd0, bus_if.busy}, 32'd0);
    tick();                                  // E33
    check({tag, "_done_fall"}, {31'd0, bus_if.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [33:0] exp;
    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    int          ec;
    int          dones;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = 32'h0;
    bus_if.b     = 32'h0;
    tick();
    tick();
    check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rst_done", {31'd0, bus_if.done}, 32'd0);
    check("rst_d",    bus_if.d, 32'd0);
    check("rst_bout", {31'd0, bus_if.bout}, 32'd0);
    check("rst_ovf",  {31'd0, bus_if.ovf}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases.
    run_op("d5m3",   32'h5,        32'h3,        32'h00000002, 1'b0, 1'b0);
    run_op("d3m5",   32'h3,        32'h5,        32'hFFFFFFFE, 1'b1, 1'b0);
    run_op("dmin",   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_op("dmax",   32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);

    // Random isolated operations against the reference.
    for (int k = 0; k < 3; k++) begin
      ra  = $urandom;
      rb  = $urandom;
      exp = ref_sub(ra, rb);
      run_op("rnd", ra, rb, exp[31:0], exp[33], exp[32]);
    end

    // Back-to-back with START held high; operands wiggle during SHIFT.
    for (int k = 0; k < 4; k++) begin
      op_a[k] = $urandom;
      op_b[k] = $urandom;
    end
    op_b[1] = op_a[1] + 32'd1;               // force a borrow-out case
    ec = 0;
    bus_if.a     = op_a[0];
    bus_if.b     = op_b[0];
    bus_if.start = 1'b1;
    tick();                                  // E0
    for (int k = 0; k < 4; k++) begin
      int n;
      n = -1;
      for (int i = 1; i <= 40; i++) begin
        tick();
        ec++;
        if (bus_if.done === 1'b1) begin
          n = i;
          break;
        end
        bus_if.a = $urandom;
        bus_if.b = $urandom;
      end
      exp = ref_sub(op_a[k], op_b[k]);
      check("b2b_edge", ec, 33 * k + 32);
      check("b2b_d", bus_if.d, exp[31:0]);
      check("b2b_bout", {31'd0, bus_if.bout}, {31'd0, exp[33]});
      check("b2b_ovf", {31'd0, bus_if.ovf}, {31'd0, exp[32]});
      if (k < 3) begin
        bus_if.a = op_a[k+1];
        bus_if.b = op_b[k+1];
        tick();                              // accept edge of next op
        ec++;
        check("b2b_rebusy", {31'd0, bus_if.busy}, 32'd1);
      end else begin
        bus_if.start = 1'b0;
      end
    end
    tick();
    check("b2b_idle_done", {31'd0, bus_if.done}, 32'd0);
    check("b2b_idle_busy", {31'd0, bus_if.busy}, 32'd0);
    exp = ref_sub(op_a[3], op_b[3]);
    tick();
    check("b2b_hold_d", bus_if.d, exp[31:0]);

    // Abort with reset at E10, then recover.
    bus_if.a     = 32'hDEADBEEF;
    bus_if.b     = 32'h00C0FFEE;
    bus_if.start = 1'b1;
    tick();                                  // E0
    bus_if.start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();     // E1..E9
    rst = 1'b1;
    bus_if.start = 1'b1;                     // reset must win over start
    tick();                                  // E10
    rst = 1'b0;
    bus_if.start = 1'b0;
    check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    check("abort_done", {31'd0, bus_if.done}, 32'd0);
    check("abort_d",    bus_if.d, 32'd0);
    check("abort_bout", {31'd0, bus_if.bout}, 32'd0);
    check("abort_ovf",  {31'd0, bus_if.ovf}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_if.done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 32'd0);
    run_op("eq", 32'h12345678, 32'h12345678, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_32.md
# serial_subtractor_32

Bit-serial 32-bit two's-complement subtractor computing D = A − B one bit per clock, LSB first. It is the subtract-side counterpart of the adder chain in the ALU datapath: where the half adder produces sum and carry, this block produces difference and borrow. The ALU uses it as a low-area multi-cycle SUB/compare unit with a start/done handshake, driven by the control unit.

## Interface
- `DATA_WIDTH`, default 32 (`DATA_INDEX_LIMIT+1` from `prj_definition.v`): operand and result width.
- `CLK  input  1  clock; all state changes on the rising edge`
- `RST  input  1  synchronous, active-high reset`
- `START  input  1  request; sampled on the rising edge`
- `A  input  32  minuend; captured on the edge that accepts START`
- `B  input  32  subtrahend; captured on the edge that accepts START`
- `D  output  32  difference register; reset 0`
- `BOUT  output  1  final borrow (1 iff A < B unsigned); reset 0`
- `OVF  output  1  signed overflow; reset 0`
- `BUSY  output  1  computation in progress; reset 0`
- `DONE  output  1  one-cycle result-valid pulse; reset 0`

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE with START=1:
  - Load the A and B shift registers.
  - Clear the borrow flip-flop and the 5-bit bit counter.
  - Go to SHIFT.
- IDLE with START=0: stay in IDLE.
- SHIFT, one bit per cycle, with a = A_sh[0], b = B_sh[0], br = borrow:
  - diff = a^b^br
  - br_next = (~a&b) | (~(a^b)&br)
  - diff shifts into the MSB of the internal difference shift register.
  - A_sh and B_sh shift right.
  - The counter increments.
- SHIFT, after bit 31 is processed:
  - Copy the internal result into D.
  - BOUT ← br_next.
  - OVF ← (A_cap[31]^B_cap[31]) & (A_cap[31]^result[31]), where A_cap and B_cap are held copies of the operand MSBs.
  - Go to DONE.
- DONE:
  - With START=1: accept a new operation (same capture actions as IDLE) and go to SHIFT.
  - Otherwise go to IDLE.
- START in SHIFT is ignored. There is no queuing.
- D, BOUT and OVF change only on the edge that enters DONE (or on reset). They hold their last result through IDLE and through the next computation.
- BUSY = (state == SHIFT). DONE = (state == DONE). Both are registered state decodes, with no combinational path from START.
- RST=1 on any edge, including mid-SHIFT:
  - state ← IDLE.
  - D, BOUT, OVF, borrow and counter ← 0.
  - No DONE pulse is produced for the aborted operation.
- RST has priority over START on the same edge.

## Timing
- Edge E0: START accepted and operands captured. BUSY=1 from E0 onward.
- Edges E1..E32: bits 0..31 processed.
- Edge E32: the state enters DONE and D/BOUT/OVF are valid. BUSY falls and DONE rises on E32.
- Edge E33: DONE falls.
- Latency: 32 cycles from the accept edge to the DONE rise.
- Throughput: one result per 33 cycles when START is held high (DONE→SHIFT directly).
- A and B may change freely after E0.

## Structure
- Shared package `prj_definition.v` holds:
  - `DATA_INDEX_LIMIT`
  - state encodings `SSUB_IDLE`, `SSUB_SHIFT`, `SSUB_DONE` (2-bit)
  - `SSUB_CNT_WIDTH` (5)
- One sub-module: `FULL_SUBTRACTOR(D,BO,A,B,BI)`, gate-level, built from xor/and/or/not primitives. It mirrors HALF_ADDER/FULL_ADDER style and is instantiated once for the serial bit slice.
- The top module holds the FSM, shift registers, counter and result registers.

## Test plan
- Reset, then START with A=5, B=3:
  - BUSY goes high at E0; DONE pulses exactly on E32.
  - Result: D=0x00000002, BOUT=0, OVF=0.
- A=3, B=5: D=0xFFFFFFFE, BOUT=1, OVF=0.
- A=0x80000000, B=0x00000001: D=0x7FFFFFFF, BOUT=0, OVF=1.
- A=0x7FFFFFFF, B=0xFFFFFFFF: D=0x80000000, BOUT=1, OVF=1.
- START held high through four back-to-back operations with varied A/B:
  - DONE pulses at E32, E65, E98 and E131.
  - Each result matches a reference model.
  - A START pulse mid-SHIFT does not disturb the result.
- Abort and recovery:
  - Assert RST at E10 of an operation: the next cycle shows BUSY=0, DONE=0, D=0, BOUT=0, OVF=0, and no DONE pulse follows.
  - Then START with A=B=0x12345678: D=0, BOUT=0, OVF=0.
